puc_multicore_top: RTL and testbench

- Parametrised next-generation top level. Instantiates NUM_CORES CPU cores and releases them from reset one after another, with a programmable stagger.
- Exposes the accumulator of one selectable core.
- Records that core's accumulator changes, tagged with pc, into a trace FIFO drained over a valid/ready handshake.
- Sits at the top of the design and replaces the single-core top for multi-core bring-up and debug.

---
 rtl/puc_pkg.sv | 41 ++++
 rtl/puc_cpu.sv | 51 +++++
 rtl/puc_trace_fifo.sv | 80 ++++++++
 rtl/puc_multicore_top.sv | 145 ++++++++++++++
 tb/tb_puc_multicore_top.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/puc_pkg.sv
// Shared widths, opcode set, trace entry layout and the bring-up program
// executed by every core.
package puc_pkg;

  localparam int REGISTER_WIDTH    = 16;
  localparam int PC_WIDTH          = 8;
  localparam int INSTRUCTION_WIDTH = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_JMP  = 4'h3
  } op_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]       pc;
    logic [REGISTER_WIDTH-1:0] acc;
  } trace_entry_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Load 5, add 3 twice with idle slots, then count up by one every two cycles.
  function automatic logic [INSTRUCTION_WIDTH-1:0] prog_rom(input int addr);
    logic [INSTRUCTION_WIDTH-1:0] w;
    case (addr)
      0:       w = {OP_LDI,  12'd5};
      1:       w = {OP_NOP,  12'd0};
      2:       w = {OP_ADDI, 12'd3};
      3:       w = {OP_ADDI, 12'd3};
      4:       w = {OP_NOP,  12'd0};
      5:       w = {OP_NOP,  12'd0};
      6:       w = {OP_ADDI, 12'd1};
      default: w = {OP_JMP,  12'd6};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/puc_cpu.sv
// Minimal single-cycle accumulator core; pc_o is the address of the
// instruction that produced the current accumulator value.
module puc_cpu
  import puc_pkg::*;
#(
  parameter int REG_W = REGISTER_WIDTH,
  parameter int PC_W  = PC_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [REG_W-1:0] acc_o,
  output logic [PC_W-1:0]  pc_o
);

  logic [PC_W-1:0]              pc_q, pc_d, lastPc_q;
  logic [REG_W-1:0]             acc_q, acc_d;
  logic [INSTRUCTION_WIDTH-1:0] instr;
  op_e                          op;
  logic [11:0]                  imm;

  assign instr = prog_rom(int'(pc_q));
  assign op    = op_e'(instr[INSTRUCTION_WIDTH-1 -: 4]);
  assign imm   = instr[11:0];

  always_comb begin
    pc_d  = pc_q + PC_W'(1);
    acc_d = acc_q;
    case (op)
      OP_LDI:  acc_d = REG_W'(imm);
      OP_ADDI: acc_d = acc_q + REG_W'(imm);
      OP_JMP:  pc_d  = PC_W'(imm);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      lastPc_q <= '0;
      acc_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      lastPc_q <= pc_q;
      acc_q    <= acc_d;
    end
  end

  assign acc_o = acc_q;
  assign pc_o  = lastPc_q;

endmodule

// File: rtl/puc_trace_fifo.sv
// First-word-fall-through FIFO with explicit occupancy, sticky drop flag and
// a synchronous clear that wins over push and pop.
module puc_trace_fifo
  import puc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = PC_WIDTH + REGISTER_WIDTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  localparam int PTR_W = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, pop, do_push;

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop     = valid_o & ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign do_push = push_i & (~full | pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (pop)     rd_d = rd_q + PTR_W'(1);
      if (do_push) wr_d = wr_q + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: ;
      endcase
      if (push_i && full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

  assign data_o     = valid_o ? mem_q[rd_q] : '0;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/puc_multicore_top.sv
// Multi-core bring-up top: staggered core reset release, observation of one
// selected accumulator and a trace of its changes.
module puc_multicore_top #(
  parameter int NUM_CORES      = 2,
  parameter int RESET_STAGGER  = 4,
  parameter int TRACE_DEPTH    = 16,
  parameter int REGISTER_WIDTH = 16,
  parameter int PC_WIDTH       = 8,
  localparam int SEL_W         = puc_pkg::clog2_min1(NUM_CORES),
  localparam int TCNT_W        = $clog2(TRACE_DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SEL_W-1:0]             coreSelect,
  input  logic                         traceEnable,
  input  logic                         traceClear,
  input  logic                         traceReady,
  output logic [REGISTER_WIDTH-1:0]    accumulator,
  output logic [NUM_CORES-1:0]         coresRunning,
  output logic                         traceValid,
  output logic [PC_WIDTH+REGISTER_WIDTH-1:0] traceData,
  output logic [TCNT_W-1:0]            traceCount,
  output logic                         traceOverflow
);

  import puc_pkg::*;

  localparam int CNT_MAX = (NUM_CORES - 1) * RESET_STAGGER;
  localparam int CNT_W   = clog2_min1(CNT_MAX + 1);

  logic                 rstMeta_q, rstSync_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CORES-1:0] running_q, running_d, runHit, cpuRst;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rstMeta_q <= 1'b0;
      rstSync_q <= 1'b0;
    end else begin
      rstMeta_q <= 1'b1;
      rstSync_q <= rstMeta_q;
    end
  end

  // Core k must be running right after edge 2+k*STAGGER; the counter reads
  // k*STAGGER-1 just before that edge, core 0 rides on the synchroniser.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_hit
    localparam int TH = g * RESET_STAGGER - 1;
    if (TH < 0) begin : g_first
      assign runHit[g] = 1'b1;
    end else begin : g_later
      assign runHit[g] = rstSync_q && (cnt_q >= CNT_W'(TH));
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!rstSync_q)                      cnt_d = '0;
    else if (cnt_q != CNT_W'(CNT_MAX))   cnt_d = cnt_q + CNT_W'(1);
    running_d = {NUM_CORES{rstMeta_q}} & (running_q | runHit);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      running_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      running_q <= running_d;
    end
  end

  assign coresRunning = running_q;

  logic [NUM_CORES-1:0][REGISTER_WIDTH-1:0] coreAcc;
  logic [NUM_CORES-1:0][PC_WIDTH-1:0]       corePc;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign cpuRst[g] = ~running_q[g];
    puc_cpu #(
      .REG_W (REGISTER_WIDTH),
      .PC_W  (PC_WIDTH)
    ) u_cpu (
      .clk_i (clock),
      .rst_i (cpuRst[g]),
      .acc_o (coreAcc[g]),
      .pc_o  (corePc[g])
    );
  end

  logic                      selValid, selRun, push;
  logic [REGISTER_WIDTH-1:0] selAcc, prevAcc_q;
  logic [PC_WIDTH-1:0]       selPc;
  logic [SEL_W-1:0]          selPrev_q;

  if (NUM_CORES == (1 << SEL_W)) begin : g_sel_full
    assign selValid = 1'b1;
  end else begin : g_sel_part
    assign selValid = (coreSelect < SEL_W'(NUM_CORES));
  end

  always_comb begin
    selAcc = '0;
    selPc  = '0;
    selRun = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (selValid && coreSelect == SEL_W'(k)) begin
        selAcc = coreAcc[k];
        selPc  = corePc[k];
        selRun = running_q[k];
      end
    end
  end

  assign accumulator = selAcc;
  // A select change only reloads the history; comparing across cores is meaningless.
  assign push = traceEnable & selRun & (selAcc != prevAcc_q) & (coreSelect == selPrev_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prevAcc_q <= '0;
      selPrev_q <= '0;
    end else begin
      prevAcc_q <= selAcc;
      selPrev_q <= coreSelect;
    end
  end

  puc_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (PC_WIDTH + REGISTER_WIDTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clear_i    (traceClear | ~rstSync_q),
    .push_i     (push),
    .data_i     ({selPc, selAcc}),
    .ready_i    (traceReady),
    .valid_o    (traceValid),
    .data_o     (traceData),
    .count_o    (traceCount),
    .overflow_o (traceOverflow)
  );

endmodule

// File: tb/tb_puc_multicore_top.sv
// Directed bench: expected trace entries are queued per phase and a
// negedge monitor compares every popped head against the queue.
module tb_puc_multicore_top;
  import puc_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        coreSelect = 1'b0;
  logic        traceEnable = 1'b0;
  logic        traceClear = 1'b0;
  logic        traceReady = 1'b0;
  logic [15:0] accumulator;
  logic [1:0]  coresRunning;
  logic        traceValid;
  logic [23:0] traceData;
  logic [2:0]  traceCount;
  logic        traceOverflow;

  int errors = 0;
  int checks = 0;
  trace_entry_t expq[$];

  puc_multicore_top #(
    .NUM_CORES      (2),
    .RESET_STAGGER  (4),
    .TRACE_DEPTH    (4),
    .REGISTER_WIDTH (16),
    .PC_WIDTH       (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .coreSelect    (coreSelect),
    .traceEnable   (traceEnable),
    .traceClear    (traceClear),
    .traceReady    (traceReady),
    .accumulator   (accumulator),
    .coresRunning  (coresRunning),
    .traceValid    (traceValid),
    .traceData     (traceData),
    .traceCount    (traceCount),
    .traceOverflow (traceOverflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic exp_push(input logic [7:0] pc, input logic [15:0] acc);
    trace_entry_t e;
    e.pc  = pc;
    e.acc = acc;
    expq.push_back(e);
  endtask

  // Pulse reset; the next rising edge after return is edge 1 of the release.
  task automatic restart();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  always @(negedge clock) begin : mon
    trace_entry_t e;
    if (traceValid && traceReady) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL trace_pop: unexpected entry %h", traceData);
      end else begin
        e = expq.pop_front();
        if (traceData !== e) begin
          errors++;
          $display("FAIL trace_data: got %h expected %h", traceData, e);
        end
      end
    end
  end

  initial begin
    // Reset release and stagger, no tracing.
    tick(3);
    chk("reset_run", {30'd0, coresRunning}, 32'd0);
    chk("reset_trace", {4'd0, traceValid, traceCount, traceOverflow, traceData}, 32'd0);
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      chk($sformatf("run_e%0d", e), {30'd0, coresRunning},
          (e >= 6) ? 32'd3 : (e >= 2) ? 32'd1 : 32'd0);
      chk($sformatf("idle_trace_e%0d", e),
          {4'd0, traceValid, traceCount, traceOverflow, traceData}, 32'd0);
    end

    // Capture of 5, 8, 11 from core 0 with a free-running consumer.
    traceEnable = 1'b1;
    traceReady  = 1'b1;
    exp_push(8'd0, 16'd5);
    exp_push(8'd2, 16'd8);
    exp_push(8'd3, 16'd11);
    restart();
    tick(3);
    chk("acc_e3", {16'd0, accumulator}, 32'd5);
    chk("latency_e3_valid", {31'd0, traceValid}, 32'd0);
    tick(1);
    chk("latency_e4_valid", {31'd0, traceValid}, 32'd1);
    chk("latency_e4_count", {29'd0, traceCount}, 32'd1);
    tick(4);
    traceEnable = 1'b0;
    tick(4);
    chk("capture_drained", expq.size(), 32'd0);
    chk("capture_empty", {31'd0, traceValid}, 32'd0);

    // Overflow: six changes into four slots, then drain.
    traceEnable = 1'b1;
    traceReady  = 1'b0;
    exp_push(8'd0, 16'd5);
    exp_push(8'd2, 16'd8);
    exp_push(8'd3, 16'd11);
    exp_push(8'd6, 16'd12);
    restart();
    tick(10);
    chk("ovf_full_count", {29'd0, traceCount}, 32'd4);
    chk("ovf_full_flag", {31'd0, traceOverflow}, 32'd0);
    tick(4);
    chk("ovf_count", {29'd0, traceCount}, 32'd4);
    chk("ovf_flag", {31'd0, traceOverflow}, 32'd1);
    chk("ovf_head", {8'd0, traceData}, {8'd0, 8'd0, 16'd5});
    traceEnable = 1'b0;
    traceReady  = 1'b1;
    tick(4);
    chk("ovf_drain_count", {29'd0, traceCount}, 32'd0);
    chk("ovf_drain_q", expq.size(), 32'd0);
    chk("ovf_sticky", {31'd0, traceOverflow}, 32'd1);

    // Full FIFO with push and pop in the same cycle.
    traceEnable = 1'b1;
    traceReady  = 1'b0;
    exp_push(8'd0, 16'd5);
    exp_push(8'd2, 16'd8);
    exp_push(8'd3, 16'd11);
    exp_push(8'd6, 16'd12);
    exp_push(8'd6, 16'd13);
    restart();
    tick(11);
    traceReady = 1'b1;
    tick(1);
    traceReady  = 1'b0;
    traceEnable = 1'b0;
    chk("pp_count", {29'd0, traceCount}, 32'd4);
    chk("pp_ovf", {31'd0, traceOverflow}, 32'd0);
    chk("pp_head", {8'd0, traceData}, {8'd0, 8'd2, 16'd8});
    traceReady = 1'b1;
    tick(4);
    chk("pp_drain_q", expq.size(), 32'd0);
    chk("pp_drain_count", {29'd0, traceCount}, 32'd0);

    // Clear racing a push, then a select switch to core 1.
    traceEnable = 1'b1;
    traceReady  = 1'b0;
    coreSelect  = 1'b0;
    exp_push(8'd3, 16'd11);
    restart();
    tick(6);
    chk("clr_pre_count", {29'd0, traceCount}, 32'd2);
    traceClear = 1'b1;
    tick(1);
    traceClear = 1'b0;
    chk("clr_state", {29'd0, traceValid, traceCount, traceOverflow}, 32'd0);
    tick(2);
    coreSelect = 1'b1;
    tick(1);
    chk("sel_no_push", {31'd0, traceValid}, 32'd0);
    chk("sel_acc", {16'd0, accumulator}, 32'd11);
    tick(1);
    chk("sel_push_valid", {31'd0, traceValid}, 32'd1);
    chk("sel_push_count", {29'd0, traceCount}, 32'd1);
    traceEnable = 1'b0;
    traceReady  = 1'b1;
    tick(2);
    chk("sel_drain_q", expq.size(), 32'd0);

    // Reset pulse while holding three entries.
    coreSelect  = 1'b0;
    traceEnable = 1'b1;
    traceReady  = 1'b0;
    restart();
    tick(7);
    chk("mid_pre_count", {29'd0, traceCount}, 32'd3);
    reset = 1'b0;
    #1;
    chk("mid_run", {30'd0, coresRunning}, 32'd0);
    chk("mid_trace", {28'd0, traceValid, traceCount}, 32'd0);
    traceEnable = 1'b0;
    tick(1);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      chk($sformatf("replay_e%0d", e), {30'd0, coresRunning},
          (e >= 6) ? 32'd3 : (e >= 2) ? 32'd1 : 32'd0);
    end
    chk("replay_empty", {28'd0, traceValid, traceCount}, 32'd0);
    chk("final_q", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
